// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID/EX hazard inputs and pipeline control outputs bundle
interface hazard_ctrl_if #(
   parameter int REG_W = 4
);
   logic             ID_Valid;
   logic [REG_W-1:0] ID_RegisterRS;
   logic [REG_W-1:0] ID_RegisterRT;
   logic             ID_UsesRT;
   logic             ID_SwapOp;
   logic             ID_DivOp;
   logic             ID_EX_MemRead;
   logic [REG_W-1:0] ID_EX_RegisterRT;
   logic             Branch_Taken;
   logic             PC_Write;
   logic             IF_ID_Write;
   logic             IF_ID_Flush;
   logic             ID_EX_Bubble;
   logic             EX_Hold;
   logic             SwapPhase;
   logic             Busy;

   // pipeline side: presents stage status, consumes control
   modport master (
      output ID_Valid, ID_RegisterRS, ID_RegisterRT, ID_UsesRT, ID_SwapOp, ID_DivOp,
             ID_EX_MemRead, ID_EX_RegisterRT, Branch_Taken,
      input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_Hold, SwapPhase, Busy
   );

   // controller side
   modport slave (
      input  ID_Valid, ID_RegisterRS, ID_RegisterRT, ID_UsesRT, ID_SwapOp, ID_DivOp,
             ID_EX_MemRead, ID_EX_RegisterRT, Branch_Taken,
      output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_Hold, SwapPhase, Busy
   );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard and multi-cycle EX sequencing controller
module hazard_ctrl #(
   parameter int REG_W   = 4,
   parameter int DIV_LAT = 8
) (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave hz
);
   typedef enum logic [1:0] {
      RUN    = 2'd0,
      SWAP_A = 2'd1,
      SWAP_B = 2'd2,
      DIV    = 2'd3
   } state_t;

   // DIV spends DIV_LAT-1 cycles in DIV (cnt counts down to 0) plus one in RUN
   localparam logic [3:0] DIV_INIT = 4'(DIV_LAT - 2);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   logic [REG_W-1:0] id_rs, id_rt, ex_rt;
   logic             load_use;
   logic             decide;

   assign id_rs = hz.ID_RegisterRS;
   assign id_rt = hz.ID_RegisterRT;
   assign ex_rt = hz.ID_EX_RegisterRT;

   // register 0 is hardwired, so a load targeting it never creates a dependency
   assign load_use = hz.ID_Valid & hz.ID_EX_MemRead & (ex_rt != '0) &
                     ((id_rs == ex_rt) | (hz.ID_UsesRT & (id_rt == ex_rt)));

   // hazard decisions are only taken when EX is free to accept a new instruction
   assign decide = (state_q == RUN) || (state_q == SWAP_B);

   // state and counter register; reset aborts any multi-cycle op
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // next-state: branch beats load-use beats DIV beats SWAP
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN, SWAP_B: begin
            if (hz.Branch_Taken) begin
               state_d = RUN;
            end else if (load_use) begin
               state_d = RUN;
            end else if (hz.ID_Valid && hz.ID_DivOp) begin
               state_d = DIV;
               cnt_d   = DIV_INIT;
            end else if (hz.ID_Valid && hz.ID_SwapOp) begin
               state_d = SWAP_A;
            end else begin
               state_d = RUN;
            end
         end
         SWAP_A: state_d = SWAP_B;
         DIV: begin
            if (cnt_q == 4'd0) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // outputs: combinational from state and current inputs
   always_comb begin
      hz.PC_Write     = 1'b1;
      hz.IF_ID_Write  = 1'b1;
      hz.IF_ID_Flush  = 1'b0;
      hz.ID_EX_Bubble = 1'b0;
      hz.EX_Hold      = 1'b0;
      hz.SwapPhase    = (state_q == SWAP_B);
      hz.Busy         = 1'b0;
      if (decide) begin
         if (hz.Branch_Taken) begin
            hz.IF_ID_Flush  = 1'b1;
            hz.ID_EX_Bubble = 1'b1;
         end else if (load_use) begin
            hz.PC_Write     = 1'b0;
            hz.IF_ID_Write  = 1'b0;
            hz.ID_EX_Bubble = 1'b1;
         end
      end else begin
         hz.EX_Hold     = 1'b1;
         hz.PC_Write    = 1'b0;
         hz.IF_ID_Write = 1'b0;
         hz.Busy        = 1'b1;
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and random checks of hazard_ctrl against a cycle model
module tb_hazard_ctrl;
   localparam int REG_W   = 4;
   localparam int DIV_LAT = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   // model: remaining EX-occupied cycles, what occupies EX, and whether the
   // current decision cycle is the second half of a SWAP
   int hold_left = 0;
   bit kind_swap = 1'b0;
   bit swap_tail = 1'b0;

   hazard_ctrl_if #(.REG_W(REG_W)) hz();

   hazard_ctrl #(.REG_W(REG_W), .DIV_LAT(DIV_LAT)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   function automatic bit model_load_use();
      return hz.ID_Valid && hz.ID_EX_MemRead && (hz.ID_EX_RegisterRT != 0) &&
             ((hz.ID_RegisterRS == hz.ID_EX_RegisterRT) ||
              (hz.ID_UsesRT && (hz.ID_RegisterRT == hz.ID_EX_RegisterRT)));
   endfunction

   task automatic model_reset();
      hold_left = 0;
      kind_swap = 1'b0;
      swap_tail = 1'b0;
   endtask

   task automatic check_out(input string tag);
      logic pc, ifid, fl, bub, hold, sp, busy;
      pc = 1; ifid = 1; fl = 0; bub = 0; hold = 0; sp = 0; busy = 0;
      if (hold_left > 0) begin
         pc = 0; ifid = 0; hold = 1; busy = 1;
      end else begin
         sp = swap_tail;
         if (hz.Branch_Taken) begin
            fl = 1; bub = 1;
         end else if (model_load_use()) begin
            pc = 0; ifid = 0; bub = 1;
         end
      end
      chk({tag, ".PC_Write"},     hz.PC_Write,     pc);
      chk({tag, ".IF_ID_Write"},  hz.IF_ID_Write,  ifid);
      chk({tag, ".IF_ID_Flush"},  hz.IF_ID_Flush,  fl);
      chk({tag, ".ID_EX_Bubble"}, hz.ID_EX_Bubble, bub);
      chk({tag, ".EX_Hold"},      hz.EX_Hold,      hold);
      chk({tag, ".SwapPhase"},    hz.SwapPhase,    sp);
      chk({tag, ".Busy"},         hz.Busy,         busy);
   endtask

   task automatic model_clock();
      if (hold_left > 0) begin
         hold_left--;
         swap_tail = (hold_left == 0) && kind_swap;
      end else begin
         swap_tail = 1'b0;
         if (!hz.Branch_Taken && !model_load_use() && hz.ID_Valid) begin
            if (hz.ID_DivOp) begin
               hold_left = DIV_LAT - 1;
               kind_swap = 1'b0;
            end else if (hz.ID_SwapOp) begin
               hold_left = 1;
               kind_swap = 1'b1;
            end
         end
      end
   endtask

   task automatic step(input string tag, input logic v, input logic [3:0] rs, input logic [3:0] rt,
                       input logic urt, input logic sw, input logic dv, input logic mr,
                       input logic [3:0] xrt, input logic br);
      @(negedge clk);
      hz.ID_Valid = v;          hz.ID_RegisterRS = rs;   hz.ID_RegisterRT = rt;
      hz.ID_UsesRT = urt;       hz.ID_SwapOp = sw;       hz.ID_DivOp = dv;
      hz.ID_EX_MemRead = mr;    hz.ID_EX_RegisterRT = xrt; hz.Branch_Taken = br;
      #1;
      check_out(tag);
      @(posedge clk);
      model_clock();
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
   endtask

   initial begin
      hz.ID_Valid = 0; hz.ID_RegisterRS = 0; hz.ID_RegisterRT = 0; hz.ID_UsesRT = 0;
      hz.ID_SwapOp = 0; hz.ID_DivOp = 0; hz.ID_EX_MemRead = 0; hz.ID_EX_RegisterRT = 0;
      hz.Branch_Taken = 0;
      model_reset();
      #2;
      check_out("reset");
      @(posedge clk);
      #1 rst = 1'b0;

      // load-use on RS, then load moves on
      step("lu_rs",     1, 4'd3, 4'd0, 0, 0, 0, 1, 4'd3, 0);
      step("lu_clear",  1, 4'd3, 4'd0, 0, 0, 0, 0, 4'd3, 0);
      step("lu_r0",     1, 4'd0, 4'd0, 1, 0, 0, 1, 4'd0, 0);
      step("lu_rt_off", 1, 4'd1, 4'd3, 0, 0, 0, 1, 4'd3, 0);
      step("lu_rt_on",  1, 4'd1, 4'd3, 1, 0, 0, 1, 4'd3, 0);
      step("lu_novalid",0, 4'd3, 4'd3, 1, 0, 0, 1, 4'd3, 0);

      // SWAP sequence, branch pulse during SWAP_A ignored
      step("swap_id",   1, 4'd1, 4'd2, 1, 1, 0, 0, 4'd0, 0);
      step("swap_a",    0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 1);
      idle("swap_b");
      idle("swap_run");

      // DIV back-to-back with branch pulses during DIV; swap in SWAP_B enters immediately
      for (int i = 0; i < 2 * DIV_LAT + 1; i++)
         step("div_b2b", 1, 4'd5, 4'd6, 1, 1, 1, 0, 4'd0, logic'(i % 3 == 1));
      step("div_to_swap", 1, 4'd5, 4'd6, 1, 1, 0, 0, 4'd0, 0);
      step("swap_a2",     1, 4'd5, 4'd6, 1, 1, 0, 0, 4'd0, 0);
      step("swap_b_swap", 1, 4'd5, 4'd6, 1, 1, 0, 0, 4'd0, 0);
      idle("swap_a3");
      idle("swap_b3");

      // branch beats load-use and swap
      step("br_prio",   1, 4'd3, 4'd0, 0, 1, 0, 1, 4'd3, 1);
      idle("br_after");

      // reset in the middle of DIV with cnt=4
      step("div_enter", 1, 4'd1, 4'd2, 0, 0, 1, 0, 4'd0, 0);
      idle("div_c6");
      idle("div_c5");
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      #1;
      check_out("rst_mid_div");
      @(posedge clk);
      #1 rst = 1'b0;
      idle("post_rst");

      // random traffic
      for (int i = 0; i < 500; i++)
         step("rand", logic'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 3)),
              4'($urandom_range(0, 3)), logic'($urandom_range(0, 1)),
              logic'($urandom_range(0, 4) == 0), logic'($urandom_range(0, 7) == 0),
              logic'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
              logic'($urandom_range(0, 5) == 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
